// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_pkg
//  Purpose  : Shared definitions for the pipeline hazard controller:
//             FSM state encoding, register-number width and the x0 constant.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

    // Register-number width of the RV64 register file (x0..x31)
    localparam int c_REG_W = 5;

    // Hard-wired zero register; never a real dependency
    localparam logic [c_REG_W-1:0] c_X0 = '0;

    // Controller states; encoding 2'd3 is illegal and recovers to ST_RUN
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_t;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_perf_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_perf_cnt
//  Purpose  : Saturating event counter with increment enable and synchronous
//             clear. Holds at all-ones instead of wrapping.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    // Count up on each enabled cycle, stop at all-ones, clear dominates
    always_ff @(posedge clk) begin
        if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != '1)) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end
    end

endmodule : hazard_perf_cnt
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Hazard controller for the 5-stage RV64 pipeline. Decides every
//             cycle whether PC / IF-ID advance, hold or flush, whether ID-EX
//             takes a bubble, and freezes the back end while data memory is
//             busy. A memory wait longer than TIMEOUT cycles traps until reset.
//  Options  : `define HAZARD_CTRL_PERF_EN adds three saturating performance
//             counters (load-use stalls, branch flushes, freeze cycles).
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [c_REG_W-1:0] rs1_id,
    input  logic [c_REG_W-1:0] rs2_id,
    input  logic               uses_rs2_id,
    input  logic [c_REG_W-1:0] rdIDEX,
    input  logic               MemReadIDEX,
    input  logic               branch_taken_ex,
    input  logic               dmem_req,
    input  logic               dmem_ready,
    output logic               PCWrite,
    output logic               IFIDWrite,
    output logic               IFIDFlush,
    output logic               IDEXFlush,
    output logic               PipeFreeze,
    output logic               mem_timeout,
    output logic [1:0]         state_o
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]   lu_stall_cnt,
    output logic [CNT_W-1:0]   br_flush_cnt,
    output logic [CNT_W-1:0]   mem_wait_cnt
`endif
);

    localparam int                c_WAIT_W      = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT_CNT = c_WAIT_W'(TIMEOUT);

    // Reject configurations the wait counter cannot support
    generate
        if ((TIMEOUT < 2) || (CNT_W < 1)) begin : g_param_check
            $error("hazard_ctrl: TIMEOUT must be >= 2 and CNT_W >= 1");
        end
    endgenerate

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                r_timeout;
    logic                w_lu;
    logic                w_ms;
    logic                w_freeze;

    // Load in EX feeding a source of the instruction in ID (x0 never counts)
    assign w_lu = MemReadIDEX && (rdIDEX != c_X0) &&
                  ((rs1_id == rdIDEX) || (uses_rs2_id && (rs2_id == rdIDEX)));

    // Data memory is being accessed but has not completed
    assign w_ms = dmem_req && !dmem_ready;

    // Next-state and wait-counter logic; freeze decision derives from state
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_freeze    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_ms) begin
                    w_freeze    = 1'b1;
                    w_state_nxt = ST_MEM_WAIT;
                    w_wait_nxt  = c_WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (w_ms) begin
                    w_freeze = 1'b1;
                    if (r_wait_cnt == c_TIMEOUT_CNT) begin
                        w_state_nxt = ST_TRAP;
                    end else begin
                        w_wait_nxt = r_wait_cnt + c_WAIT_W'(1);
                    end
                end else begin
                    // Release: RUN rules apply combinationally this cycle
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            end
            ST_TRAP: begin
                w_freeze = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Pipeline-register enables: reset, freeze, branch, load-use, normal
    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        PipeFreeze = 1'b0;
        if (RST) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (w_freeze) begin
            PipeFreeze = 1'b1;
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
        end else if (branch_taken_ex) begin
            // Squash both younger instructions; lu consumer is flushed anyway
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end else if (w_lu) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_timeout  <= r_timeout | (w_state_nxt == ST_TRAP);
        end
    end

    assign mem_timeout = r_timeout && !RST;
    assign state_o     = RST ? ST_RUN : r_state;

`ifdef HAZARD_CTRL_PERF_EN
    logic             w_lu_inc;
    logic             w_br_inc;
    logic [CNT_W-1:0] w_lu_cnt;
    logic [CNT_W-1:0] w_br_cnt;
    logic [CNT_W-1:0] w_frz_cnt;

    assign w_br_inc = !RST && !w_freeze && branch_taken_ex;
    assign w_lu_inc = !RST && !w_freeze && !branch_taken_ex && w_lu;

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk   (CLK),
        .i_clr (RST),
        .i_inc (w_lu_inc),
        .o_cnt (w_lu_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_br_cnt (
        .clk   (CLK),
        .i_clr (RST),
        .i_inc (w_br_inc),
        .o_cnt (w_br_cnt)
    );

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_frz_cnt (
        .clk   (CLK),
        .i_clr (RST),
        .i_inc (PipeFreeze),
        .o_cnt (w_frz_cnt)
    );

    assign lu_stall_cnt = RST ? '0 : w_lu_cnt;
    assign br_flush_cnt = RST ? '0 : w_br_cnt;
    assign mem_wait_cnt = RST ? '0 : w_frz_cnt;
`endif

endmodule : hazard_ctrl
`default_nettype wire
